// File: rtl/alu_muldiv_control_unit_pkg.sv
// Shared encodings for the EX-stage ALU control and the iterative mul/div unit.
package alu_muldiv_control_unit_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_XOR  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_BEQ  = 5'd7;
  localparam logic [4:0] ALU_BNE  = 5'd8;
  localparam logic [4:0] ALU_BLT  = 5'd9;
  localparam logic [4:0] ALU_BGE  = 5'd10;
  localparam logic [4:0] ALU_SRA  = 5'd11;
  localparam logic [4:0] ALU_SLT  = 5'd12;
  localparam logic [4:0] ALU_SLTU = 5'd13;
  localparam logic [4:0] ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15;

  // Base-ALU decode; f7b5 is funct7[5], the SUB/SRA selector.
  function automatic logic [4:0] decode_alu_op(input logic [6:0] opc, input logic [2:0] f3,
                                               input logic f7b5);
    logic [4:0] op;
    op = ALU_ADD;
    if (opc == OPC_OP || opc == OPC_OPIMM) begin
      case (f3)
        3'd0:    op = (opc == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
        3'd1:    op = ALU_SLL;
        3'd2:    op = ALU_SLT;
        3'd3:    op = ALU_SLTU;
        3'd4:    op = ALU_XOR;
        3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
        3'd6:    op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end else if (opc == OPC_BRANCH) begin
      case (f3)
        3'd0:    op = ALU_BEQ;
        3'd1:    op = ALU_BNE;
        3'd4:    op = ALU_BLT;
        3'd5:    op = ALU_BGE;
        3'd6:    op = ALU_BLTU;
        3'd7:    op = ALU_BGEU;
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_muldiv_control_unit_iter_datapath.sv
// Operand/accumulator registers for the shift-add multiplier and restoring
// divider, plus special-case detection and the final sign fix-up.
module alu_muldiv_control_unit_iter_datapath
  import alu_muldiv_control_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            special,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   m_reg, a_abs, b_abs, dv;
  logic [2:0]        op;
  logic              neg, a_neg, b_neg, div_zero, div_ovf, mul_zero;
  logic [XLEN:0]     mul_sum, div_t, div_diff;

  // Signedness: rs1 signed for MULH/MULHSU/DIV/REM, rs2 signed for MULH/DIV/REM.
  assign a_neg = rs1_data[XLEN-1] &&
                 (funct3 == FUNCT3_MULH || funct3 == FUNCT3_MULHSU ||
                  funct3 == FUNCT3_DIV  || funct3 == FUNCT3_REM);
  assign b_neg = rs2_data[XLEN-1] &&
                 (funct3 == FUNCT3_MULH || funct3 == FUNCT3_DIV || funct3 == FUNCT3_REM);
  assign a_abs = a_neg ? -rs1_data : rs1_data;
  assign b_abs = b_neg ? -rs2_data : rs2_data;

  assign div_zero = funct3[2] && rs2_data == '0;
  assign div_ovf  = funct3[2] && !funct3[0] && rs2_data == '1 &&
                    rs1_data == {1'b1, {(XLEN-1){1'b0}}};
  assign mul_zero = (EARLY_OUT != 0) && !funct3[2] && (rs1_data == '0 || rs2_data == '0);
  assign special  = div_zero || div_ovf || mul_zero;

  // One iteration: multiplier adds m when acc[0] is set then shifts right;
  // divider shifts {rem,dividend} left and subtracts the divisor if it fits.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_reg} : '0);
  assign div_t    = acc[2*XLEN-1:XLEN-1];
  assign div_diff = div_t - {1'b0, m_reg};

  // Special cases pre-load acc so the common fix-up yields the fixed answer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      m_reg <= '0;
      op    <= '0;
      neg   <= 1'b0;
    end else if (start) begin
      op    <= funct3;
      m_reg <= b_abs;
      neg   <= 1'b0;
      if (div_zero)      acc <= {rs1_data, {XLEN{1'b1}}};
      else if (div_ovf)  acc <= {{XLEN{1'b0}}, rs1_data};
      else if (mul_zero) acc <= '0;
      else begin
        acc <= {{XLEN{1'b0}}, a_abs};
        neg <= (funct3 == FUNCT3_REM) ? a_neg : (a_neg ^ b_neg);
      end
    end else if (step) begin
      if (op[2]) begin
        if (!div_diff[XLEN]) acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else                 acc <= {acc[2*XLEN-2:0], 1'b0};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

  assign prod = neg ? -acc : acc;
  assign dv   = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

  // Result select: quotient/remainder with sign, or low/high product half.
  always_comb begin
    result = '0;
    if (op[2])               result = neg ? -dv : dv;
    else if (op[1:0] == 2'd0) result = prod[XLEN-1:0];
    else                     result = prod[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/alu_muldiv_control_unit.sv
// EX-stage ALU control: base-ALU decode plus the mul/div sequencing FSM,
// iteration counter and pipeline stall.
module alu_muldiv_control_unit
  import alu_muldiv_control_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int OP_W      = 5,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic [OP_W-1:0] alu_op,
  output logic            is_muldiv,
  output logic            stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, busy, last_step, special;
  logic [XLEN-1:0]  dp_result, held;

  assign is_muldiv = opcode == OPC_OP && funct7 == FUNCT7_MULDIV;
  assign alu_op    = is_muldiv ? OP_W'(ALU_ADD) : OP_W'(decode_alu_op(opcode, funct3, funct7[5]));

  assign accept    = state == S_IDLE && in_valid && is_muldiv && !flush;
  assign busy      = state == S_MUL || state == S_DIV;
  assign stall     = accept || busy;
  assign last_step = cnt == CNT_W'(XLEN - 1);

  // DONE lasts exactly one cycle so a still-presented instruction never restarts.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (accept) state_nxt = special ? S_DONE : (funct3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (last_step) state_nxt = S_DONE;
      default:      state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Iteration counter; saturates at XLEN when the loop exits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               cnt <= '0;
    else if (accept)                         cnt <= '0;
    else if (busy && cnt != CNT_W'(XLEN))    cnt <= cnt + 1'b1;
  end

  // Last delivered result, shown whenever no completion is being strobed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         held <= '0;
    else if (md_valid) held <= dp_result;
  end

  assign md_valid  = state == S_DONE && !flush;
  assign md_result = md_valid ? dp_result : held;

  alu_muldiv_control_unit_iter_datapath #(.XLEN(XLEN), .EARLY_OUT(EARLY_OUT)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .step     (busy),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .special  (special),
    .result   (dp_result)
  );

endmodule

// File: tb/tb_alu_muldiv_control_unit.sv
// Bench for alu_muldiv_control_unit: directed literal cases plus randomized
// traffic checked every cycle against an arithmetic reference model.
module tb_alu_muldiv_control_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0;
  logic [6:0]  opcode = 7'h0, funct7 = 7'h0;
  logic [2:0]  funct3 = 3'h0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [4:0]  alu_op;
  logic        is_muldiv, stall, md_valid;
  logic [31:0] md_result;

  int checks = 0, failures = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv_control_unit #(.XLEN(XLEN), .OP_W(5), .EARLY_OUT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .alu_op(alu_op), .is_muldiv(is_muldiv), .stall(stall), .md_valid(md_valid),
    .md_result(md_result)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    pu = {32'b0, a} * {32'b0, b};
    case (f3)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit md_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) ||
           (!f3[2] && (a == 0 || b == 0));
  endfunction

  function automatic bit md_instr(input logic [6:0] opc, input logic [6:0] f7);
    return opc == 7'h33 && f7 == 7'h01;
  endfunction

  function automatic logic [4:0] dec_ref(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    if (opc == 7'h33 || opc == 7'h13) begin
      case (f3)
        3'd0: return (opc == 7'h33 && f7[5]) ? 5'd1 : 5'd0;
        3'd1: return 5'd2;
        3'd2: return 5'd12;
        3'd3: return 5'd13;
        3'd4: return 5'd3;
        3'd5: return f7[5] ? 5'd11 : 5'd6;
        3'd6: return 5'd4;
        default: return 5'd5;
      endcase
    end
    if (opc == 7'h63) begin
      case (f3)
        3'd0: return 5'd7;
        3'd1: return 5'd8;
        3'd4: return 5'd9;
        3'd5: return 5'd10;
        3'd6: return 5'd14;
        3'd7: return 5'd15;
        default: return 5'd0;
      endcase
    end
    return 5'd0;
  endfunction

  // phase = cycles left until the completion cycle (1 = completion cycle, 0 = free)
  int          phase = 0;
  logic [31:0] cur_res = '0, held_res = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase = 0;
      held_res = '0;
    end else if (flush) begin
      phase = 0;
    end else if (phase == 0) begin
      if (in_valid && md_instr(opcode, funct7)) begin
        cur_res = md_ref(funct3, rs1_data, rs2_data);
        phase = md_fast(funct3, rs1_data, rs2_data) ? 1 : XLEN + 1;
      end
    end else begin
      if (phase == 1) held_res = cur_res;
      phase = phase - 1;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (run_chk && !reset) begin
      bit exp_md, exp_stall, exp_vld;
      exp_md    = md_instr(opcode, funct7);
      exp_stall = (phase == 0 && in_valid && exp_md && !flush) || phase > 1;
      exp_vld   = phase == 1 && !flush;
      check("is_muldiv", 64'(is_muldiv), 64'(exp_md));
      if (!exp_md) check("alu_op", 64'(alu_op), 64'(dec_ref(opcode, funct3, funct7)));
      check("stall", 64'(stall), 64'(exp_stall));
      check("md_valid", 64'(md_valid), 64'(exp_vld));
      check("md_result", 64'(md_result), 64'(exp_vld ? cur_res : held_res));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; opcode = 7'h33; funct7 = 7'h01; funct3 = f3;
    rs1_data = a; rs2_data = b; flush = 1'b0;
  endtask

  task automatic run_md(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n, st;
    @(posedge clk); #1;
    drive_md(f3, a, b);
    #1;
    n = 0; st = 0;
    while (!md_valid && n < 100) begin
      if (stall) st++;
      @(posedge clk); #2;
      n++;
    end
    check({nm, "_lat"}, 64'(n), 64'(lat));
    check({nm, "_stallcyc"}, 64'(st), 64'(lat));
    check({nm, "_res"}, 64'(md_result), 64'(exp));
    check({nm, "_done_stall"}, 64'(stall), 64'd0);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 9);
    in_valid = $urandom_range(0, 7) != 0;
    funct3 = 3'($urandom_range(0, 7));
    funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    rs1_data = pick_val();
    rs2_data = pick_val();
    if (k <= 5)      begin opcode = 7'h33; funct7 = 7'h01; end
    else if (k == 6) opcode = 7'h33;
    else if (k == 7) opcode = 7'h13;
    else if (k == 8) opcode = 7'h63;
    else begin
      case ($urandom_range(0, 3))
        0: opcode = 7'h03;
        1: opcode = 7'h23;
        2: opcode = 7'h67;
        default: opcode = 7'($urandom);
      endcase
    end
  endtask

  typedef struct {logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [4:0] exp; string nm;} dec_vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t dv[14];
    int n;
    dv = '{'{7'h33, 3'd0, 7'h00, 5'd0,  "ADD"},  '{7'h33, 3'd0, 7'h20, 5'd1,  "SUB"},
           '{7'h33, 3'd5, 7'h20, 5'd11, "SRA"},  '{7'h13, 3'd5, 7'h20, 5'd11, "SRAI"},
           '{7'h33, 3'd2, 7'h00, 5'd12, "SLT"},  '{7'h33, 3'd3, 7'h00, 5'd13, "SLTU"},
           '{7'h63, 3'd6, 7'h00, 5'd14, "BLTU"}, '{7'h63, 3'd7, 7'h00, 5'd15, "BGEU"},
           '{7'h03, 3'd2, 7'h00, 5'd0,  "LW"},   '{7'h23, 3'd2, 7'h00, 5'd0,  "SW"},
           '{7'h63, 3'd0, 7'h00, 5'd7,  "BEQ"},  '{7'h63, 3'd1, 7'h00, 5'd8,  "BNE"},
           '{7'h33, 3'd5, 7'h00, 5'd6,  "SRL"},  '{7'h13, 3'd4, 7'h00, 5'd3,  "XORI"}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_md_valid", 64'(md_valid), 64'd0);
    check("rst_md_result", 64'(md_result), 64'd0);
    reset = 1'b0;
    run_chk = 1'b1;

    run_md("MUL",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_md("MULHU",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_md("MULH",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_md("MULHSU", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_md("DIV",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_md("REM",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_md("DIVU",   3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_md("REMU",   3'd7, 32'd100,      32'd7,        32'd2,        33);

    // flush ten cycles into a divide: no strobe, result keeps the REMU value
    @(posedge clk); #1;
    drive_md(3'd4, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b0;
    #1;
    check("flush_stall_in_div", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_idle_stall", 64'(stall), 64'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk); #2;
      if (md_valid) n++;
    end
    check("flush_no_valid", 64'(n), 64'd0);
    check("flush_result_kept", 64'(md_result), 64'd2);

    run_md("DIVU_by0",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_md("REM_by0",   3'd6, 32'd5,        32'd0,        32'd5,        1);
    run_md("DIV_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("REM_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
    run_md("MULH_zero", 3'd1, 32'h0,        32'h12345678, 32'h0,        1);

    // async reset in the middle of a multiply
    @(posedge clk); #1;
    drive_md(3'd0, 32'd7, 32'hFFFFFFFD);
    repeat (6) @(posedge clk);
    #1;
    run_chk = 1'b0;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    check("areset_stall", 64'(stall), 64'd0);
    check("areset_md_valid", 64'(md_valid), 64'd0);
    check("areset_md_result", 64'(md_result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_chk = 1'b1;
    run_md("MUL_after_rst", 3'd0, 32'd123, 32'd456, 32'd56088, 33);

    // base decode sweep
    foreach (dv[i]) begin
      @(posedge clk); #1;
      in_valid = 1'b1; opcode = dv[i].opc; funct3 = dv[i].f3; funct7 = dv[i].f7;
      rs1_data = $urandom; rs2_data = $urandom;
      #1;
      check({"dec_", dv[i].nm}, 64'(alu_op), 64'(dv[i].exp));
      check({"dec_md_", dv[i].nm}, 64'(is_muldiv), 64'd0);
      check({"dec_stall_", dv[i].nm}, 64'(stall), 64'd0);
    end

    // randomized traffic: inputs held while stalled, occasional flush
    repeat (6000) begin
      @(posedge clk); #1;
      if (!stall) rand_instr();
      flush = $urandom_range(0, 39) == 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    run_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
